jtag_debug_scan_host: RTL
=========================

# jtag_debug_scan_host

Host-side JTAG scan engine that drives the 2-bit-IR / 38-bit-DR debug TAP of the Nios II JTAG debug module from fabric logic. It accepts an IR+DR scan command, generates TCK/TMS/TDI, walks the IEEE 1149.1 TAP state machine, and returns the captured TDO data. It sits between a bench or in-system debug controller and the debug module's JTAG pins or virtual-JTAG hub.

## Interface
- IR_WIDTH, 2, instruction register length (debug module ir_in width)
- DR_WIDTH, 38, data register length (debug module sr/jdo width)
- TCK_DIV, 4, clk cycles per TCK half-period; legal range ≥1
- clk  in  1  system clock; the only clock
- reset_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  engine idle in Run-Test/Idle, command accepted when cmd_valid&&cmd_ready
- cmd_skip_ir  in  1  1 = DR scan only, IR left unchanged
- cmd_ir  in  IR_WIDTH  instruction to shift, LSB first
- cmd_dr  in  DR_WIDTH  data to shift, LSB first
- rsp_valid  out  1  one-cycle pulse, scan complete
- rsp_ir  out  IR_WIDTH  TDO bits captured during IR shift (held until next rsp_valid)
- rsp_dr  out  DR_WIDTH  TDO bits captured during DR shift (held until next rsp_valid)
- tck  out  1  JTAG clock
- tms  out  1  JTAG mode select
- tdi  out  1  JTAG data to target
- tdo  in  1  JTAG data from target

## Operation
- Reset values: tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_ir=0, rsp_dr=0.
- TCK cycle = low phase (TCK_DIV clks) then high phase (TCK_DIV clks). tms/tdi update only on the clk edge that drives tck low. tdo is sampled on the clk edge that drives tck high.
- States: INIT, IDLE, IR_HDR, IR_SHIFT, IR_TAIL, DR_HDR, DR_SHIFT, DR_TAIL.
- INIT: 5 TCK with tms=1 (Test-Logic-Reset), then 1 TCK with tms=0 (Run-Test/Idle). Next state is IDLE.
- IDLE: cmd_ready=1, tck held 0, tms=0. On accept, latch cmd_* and drop cmd_ready on the next edge. Go to IR_HDR, or to DR_HDR if cmd_skip_ir=1.
- IR_HDR: tms 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR).
- IR_SHIFT: IR_WIDTH TCKs. tdi=cmd_ir[i]. tms=0, except tms=1 on the last bit (Exit1-IR). tdo sampled in TCK i goes to rsp_ir[i].
- IR_TAIL: tms 1,0 (Update-IR, Run-Test/Idle). Next state is DR_HDR.
- DR_HDR: tms 1,0,0 (Select-DR, Capture-DR, Shift-DR).
- DR_SHIFT: DR_WIDTH TCKs. tdi=cmd_dr[i], tms=1 on the last bit only. tdo sampled in TCK i goes to rsp_dr[i].
- DR_TAIL: tms 1,0 (Update-DR, Run-Test/Idle). Then rsp_valid=1 for one clk, rsp_ir/rsp_dr updated, next state is IDLE.
- Outside the shift states tdi=0. When cmd_skip_ir=1, rsp_ir keeps its previous value.
- cmd_valid while cmd_ready=0 is ignored; no queuing. rsp has no backpressure.
- Reset asserted mid-scan: all outputs return to their reset values immediately; the in-flight command is dropped with no rsp. After release the engine re-runs INIT.

## Timing
- Full command length: IR_WIDTH+DR_WIDTH+11 TCKs, which is 51 with defaults. Skip-IR command: DR_WIDTH+5 TCKs, which is 43.
- Accept at clk edge A. The first low phase starts at A+1. rsp_valid is high in cycle A+1+N·2·TCK_DIV, where N is the TCK count. cmd_ready rises in the same cycle as rsp_valid.
- Back-to-back commands: cmd_valid held high gives the next accept in the rsp_valid cycle; the next low phase starts on the following edge.
- INIT starts on the first clk edge after reset release. cmd_ready rises 12·TCK_DIV cycles later.
- Every TCK high and low phase lasts exactly TCK_DIV clks, with no stretching. tck is a registered output, glitch-free.

## Test plan
- Reset release, TCK_DIV=4 -> exactly 5 TCK with tms=1 then 1 with tms=0; cmd_ready=1 at cycle 48; tdi=0 throughout.
- TAP model with IR loopback capture 2'b01 and DR register preloaded 38'h2A_5A5A_5A5A; command cmd_ir=2'b10, cmd_dr=38'h15_A5A5_A5A5 -> model sees IR=2'b10 and DR=cmd_dr at Update; rsp_ir=2'b01, rsp_dr=38'h2A_5A5A_5A5A; rsp_valid at A+1+408.
- cmd_skip_ir=1, cmd_dr=38'h3F_FFFF_FFFF -> model IR unchanged, 43 TCKs, rsp_valid at A+1+344, rsp_ir holds previous 2'b01.
- Two commands with cmd_valid held high -> second accept in the first rsp_valid cycle; no extra TCK between scans; model TAP returns to Run-Test/Idle between them.
- reset_n pulsed low during DR_SHIFT bit 20 -> same-cycle tck=0, tms=1, tdi=0, cmd_ready=0; no rsp_valid; INIT sequence repeats after release.
- TCK_DIV=1 -> tck toggles every clk; a full IR+DR scan completes at A+1+102 with correct data.

Source files
------------

// File: rtl/jtag_debug_scan_host.sv
// jtag_debug_scan_host: host-side IR+DR scan engine driving the Nios II debug TAP
//   clk, reset_n         : system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  : command handshake, accepted only in Run-Test/Idle
//   cmd_skip_ir, cmd_ir, cmd_dr : scan command, shifted LSB first
//   rsp_valid, rsp_ir, rsp_dr   : one-cycle completion pulse with captured TDO bits
//   tck, tms, tdi, tdo   : JTAG pins, tck period = 2*TCK_DIV clks
module jtag_debug_scan_host #(
   parameter int IR_WIDTH = 2,
   parameter int DR_WIDTH = 38,
   parameter int TCK_DIV  = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_skip_ir,
   input  logic [IR_WIDTH-1:0] cmd_ir,
   input  logic [DR_WIDTH-1:0] cmd_dr,
   output logic                rsp_valid,
   output logic [IR_WIDTH-1:0] rsp_ir,
   output logic [DR_WIDTH-1:0] rsp_dr,
   output logic                tck,
   output logic                tms,
   output logic                tdi,
   input  logic                tdo
);
   localparam int IW = $clog2(IR_WIDTH + DR_WIDTH + 8);
   localparam int CW = $clog2(TCK_DIV + 1);
   typedef enum logic [2:0] {INIT, IDLE, IR_HDR, IR_SHIFT, IR_TAIL, DR_HDR, DR_SHIFT, DR_TAIL} state_t;
   state_t              state, nxt_state;
   logic [IW-1:0]       idx, nxt_idx;
   logic [CW-1:0]       cnt;
   logic                hi, first, skip_q, accept, lo_edge, hi_edge, tms_n, tdi_n;
   logic [IR_WIDTH-1:0] ir_q, cap_ir;
   logic [DR_WIDTH-1:0] dr_q, cap_dr;
   function automatic logic is_last(state_t s, logic [IW-1:0] i);
      return i == (s == INIT ? IW'(5) : s == IR_HDR ? IW'(3) : s == IR_SHIFT ? IW'(IR_WIDTH - 1) :
                   s == DR_HDR ? IW'(2) : s == DR_SHIFT ? IW'(DR_WIDTH - 1) : IW'(1));
   endfunction
   // first marks a position that was just entered (reset or accept) and must be
   // driven on the next edge without advancing; every other low edge advances
   always_comb begin
      accept    = cmd_valid && cmd_ready;
      lo_edge   = state != IDLE && (first || (hi && cnt == CW'(TCK_DIV - 1)));
      hi_edge   = state != IDLE && !first && !hi && cnt == CW'(TCK_DIV - 1);
      nxt_state = state;
      nxt_idx   = idx;
      if (accept) begin
         nxt_state = cmd_skip_ir ? DR_HDR : IR_HDR;
         nxt_idx   = '0;
      end else if (lo_edge && !first) begin
         nxt_idx = is_last(state, idx) ? '0 : idx + 1'b1;
         if (is_last(state, idx))
            nxt_state = state == IR_HDR ? IR_SHIFT : state == IR_SHIFT ? IR_TAIL : state == IR_TAIL ? DR_HDR :
                        state == DR_HDR ? DR_SHIFT : state == DR_SHIFT ? DR_TAIL : IDLE;
      end
      tms_n = nxt_state == INIT ? !is_last(nxt_state, nxt_idx) :
              nxt_state == IR_HDR ? nxt_idx < IW'(2) :
              nxt_state inside {IR_SHIFT, DR_SHIFT} ? is_last(nxt_state, nxt_idx) :
              nxt_state inside {IR_TAIL, DR_HDR, DR_TAIL} ? nxt_idx == '0 : 1'b0;
      tdi_n = nxt_state == IR_SHIFT ? ir_q[0] : nxt_state == DR_SHIFT ? dr_q[0] : 1'b0;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= INIT;
         idx       <= '0;
         cnt       <= '0;
         hi        <= 1'b0;
         first     <= 1'b1;
         skip_q    <= 1'b0;
         ir_q      <= '0;
         dr_q      <= '0;
         cap_ir    <= '0;
         cap_dr    <= '0;
         tck       <= 1'b0;
         tms       <= 1'b1;
         tdi       <= 1'b0;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_ir    <= '0;
         rsp_dr    <= '0;
      end else begin
         state     <= nxt_state;
         idx       <= nxt_idx;
         rsp_valid <= 1'b0;
         if (accept) begin
            cmd_ready <= 1'b0;
            first     <= 1'b1;
            skip_q    <= cmd_skip_ir;
            ir_q      <= cmd_ir;
            dr_q      <= cmd_dr;
         end else if (lo_edge) begin
            first <= 1'b0;
            hi    <= 1'b0;
            cnt   <= '0;
            tck   <= 1'b0;
            tms   <= tms_n;
            tdi   <= tdi_n;
            if (nxt_state == IR_SHIFT) ir_q <= ir_q >> 1;
            if (nxt_state == DR_SHIFT) dr_q <= dr_q >> 1;
            if (nxt_state == IDLE) begin
               cmd_ready <= 1'b1;
               rsp_valid <= state == DR_TAIL;
               if (state == DR_TAIL) begin
                  rsp_dr <= cap_dr;
                  if (!skip_q) rsp_ir <= cap_ir;
               end
            end
         end else if (hi_edge) begin
            hi  <= 1'b1;
            cnt <= '0;
            tck <= 1'b1;
            if (state == IR_SHIFT) cap_ir <= IR_WIDTH'({tdo, cap_ir} >> 1);
            if (state == DR_SHIFT) cap_dr <= DR_WIDTH'({tdo, cap_dr} >> 1);
         end else if (state != IDLE) begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule
